// File: rtl/axis_video_framer.sv
// axis_video_framer: frames a 32-bit AXI4-Stream pixel stream into lines and
// frames, regenerating tuser/tlast from counters and counting framing errors.
// Ports: axis_aclk / axis_aresetn (async, active-low) clock and reset;
//   enable / fsync frame start control; s_axis_* upstream beats (registered
//   tready); m_axis_* framed beats from a 2-entry skid buffer; frame_count and
//   err_count status counters; busy while a frame is being framed.
module axis_video_framer #(
   parameter int unsigned LINE_BEATS  = 320,
   parameter int unsigned FRAME_LINES = 480
) (
   input  logic        axis_aclk,
   input  logic        axis_aresetn,
   input  logic        enable,
   input  logic        fsync,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tuser,
   output logic        m_axis_tlast,
   output logic [15:0] frame_count,
   output logic [15:0] err_count,
   output logic        busy
);

   typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DROP} state_e;

   typedef struct packed {
      logic [31:0] data;
      logic        user;
      logic        last;
   } beat_t;

   localparam logic [11:0] BEAT_LAST = 12'(LINE_BEATS - 1);
   localparam logic [11:0] LINE_LAST = 12'(FRAME_LINES - 1);

   state_e      state_q, state_d;
   logic [11:0] beat_q, beat_d;
   logic [11:0] line_q, line_d;
   logic        sof_q, sof_d;
   logic [15:0] frame_q, frame_d;
   logic [15:0] err_q, err_d;
   logic        rdy_q, rdy_d;
   beat_t       ent0_q, ent0_d;
   beat_t       ent1_q, ent1_d;
   logic [1:0]  cnt_q, cnt_d;

   state_e      st;
   logic [11:0] bc, lc;
   logic        sof;
   logic        acc, pop, push, room;
   logic        restart_err, beat_err;
   beat_t       in_beat;

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      line_d      = line_q;
      sof_d       = sof_q;
      frame_d     = frame_q;
      err_d       = err_q;
      ent0_d      = ent0_q;
      ent1_d      = ent1_q;
      cnt_d       = cnt_q;
      push        = 1'b0;
      restart_err = 1'b0;
      beat_err    = 1'b0;

      acc  = s_axis_tvalid && rdy_q;
      pop  = (cnt_q != 2'd0) && m_axis_tready;
      // a beat arriving with fsync while leftovers fill the buffer has no slot
      room = (cnt_q != 2'd2) || pop;

      // fsync resolves first so a coincident beat sees the new frame context
      st  = state_q;
      bc  = beat_q;
      lc  = line_q;
      sof = sof_q;
      if (fsync) begin
         restart_err = (state_q == ACTIVE) &&
                       ((beat_q != 12'd0) || (line_q != 12'd0));
         if (enable) begin
            st  = ACTIVE;
            bc  = 12'd0;
            lc  = 12'd0;
            sof = 1'b1;
         end else if (state_q == ACTIVE) begin
            st = WAIT_SOF;
         end
      end
      state_d = st;
      beat_d  = bc;
      line_d  = lc;
      sof_d   = sof;

      in_beat.data = s_axis_tdata;
      in_beat.user = sof;
      in_beat.last = (bc == BEAT_LAST) || s_axis_tlast;

      if ((st == ACTIVE) && acc && room) begin
         push  = 1'b1;
         sof_d = 1'b0;
         if (s_axis_tlast != (bc == BEAT_LAST)) begin
            beat_err = 1'b1;
            state_d  = DROP;
         end else if (bc == BEAT_LAST) begin
            beat_d = 12'd0;
            if (lc == LINE_LAST) begin
               line_d  = 12'd0;
               frame_d = frame_q + 16'd1;
               state_d = WAIT_SOF;
            end else begin
               line_d = lc + 12'd1;
            end
         end else begin
            beat_d = bc + 12'd1;
         end
      end

      if ((restart_err || beat_err) && (err_q != 16'hFFFF)) begin
         err_d = err_q + 16'd1;
      end

      // entry 0 is the output register, entry 1 the skid slot
      if (pop) begin
         if (cnt_q == 2'd2) begin
            ent0_d = ent1_q;
         end
         cnt_d = cnt_q - 2'd1;
      end
      if (push) begin
         if (cnt_d == 2'd0) begin
            ent0_d = in_beat;
         end else begin
            ent1_d = in_beat;
         end
         cnt_d = cnt_d + 2'd1;
      end

      rdy_d = (state_d != ACTIVE) || (cnt_d != 2'd2);
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q <= WAIT_SOF;
         beat_q  <= 12'd0;
         line_q  <= 12'd0;
         sof_q   <= 1'b0;
         frame_q <= 16'd0;
         err_q   <= 16'd0;
         rdy_q   <= 1'b0;
         ent0_q  <= '0;
         ent1_q  <= '0;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         line_q  <= line_d;
         sof_q   <= sof_d;
         frame_q <= frame_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         cnt_q   <= cnt_d;
      end
   end

   assign s_axis_tready = rdy_q;
   assign m_axis_tvalid = (cnt_q != 2'd0);
   assign m_axis_tdata  = ent0_q.data;
   assign m_axis_tuser  = ent0_q.user;
   assign m_axis_tlast  = ent0_q.last;
   assign frame_count   = frame_q;
   assign err_count     = err_q;
   assign busy          = (state_q == ACTIVE);

endmodule
